mem_port_arbiter: RTL and testbench

//  Shares one single-port main memory between the risc_v_32 instruction-fetch port and its load/store port.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and main-memory port that
// mem_port_arbiter sits between. slave = arbiter view, master = CPU/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_valid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic [1:0]        d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] m_addr;
    logic [1:0]        m_wr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    logic              stall;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, m_rdata,
        output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
               m_addr, m_wr, m_wdata, stall
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
               m_addr, m_wr, m_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch port and
// the load/store port. One access per MEM_LAT cycles, data priority with a
// starvation guard for fetch.
// Build option: define ARB_RR_EN for strict round-robin on ties (no starve
// counter; the first tie after reset goes to fetch).
//
// state | meaning
// IDLE  | no access in flight, slot free
// BUSY  | access in flight; cnt counts down to the cycle its data/ack returns
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              slot_done, slot_free;
    logic              win_i, win_d;

`ifdef ARB_RR_EN
    logic last_d_q, last_d_d;
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    logic [SW-1:0] starve_q, starve_d;
`endif

    // Arbitration, slot FSM next state and fairness bookkeeping
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        win_i     = 1'b0;
        win_d     = 1'b0;
        slot_done = (state_q == BUSY) && (cnt_q == '0);
        slot_free = (state_q == IDLE) || slot_done;
`ifdef ARB_RR_EN
        last_d_d  = last_d_q;
`else
        starve_d  = starve_q;
`endif

        if (rst && slot_free) begin
            if (bus.i_req && bus.d_req) begin
`ifdef ARB_RR_EN
                win_i = last_d_q;
`else
                win_i = (starve_q == STARVE_LIM);
`endif
                win_d = !win_i;
            end else begin
                win_i = bus.i_req;
                win_d = bus.d_req;
            end
        end

        if (win_i || win_d) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
            owner_d = win_i ? OWN_I : OWN_D;
        end else if (slot_done) begin
            state_d = IDLE;
            owner_d = OWN_NONE;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - 1'b1;
        end

`ifdef ARB_RR_EN
        if (win_d) last_d_d = 1'b1;
        else if (win_i) last_d_d = 1'b0;
`else
        // A lost arbitration is a free slot where fetch asked and was not chosen
        if (!bus.i_req || win_i) starve_d = '0;
        else if (rst && slot_free && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
`endif
    end

    // Grants, memory-side drive (held when idle) and returned data steering
    always_comb begin
        bus.i_gnt   = win_i;
        bus.d_gnt   = win_d;
        bus.m_addr  = win_d ? bus.d_addr : (win_i ? bus.i_addr : addr_q);
        bus.m_wr    = win_d ? bus.d_wr : 2'b00;
        bus.m_wdata = win_d ? bus.d_wdata : (win_i ? '0 : wdata_q);
        bus.i_valid = rst && slot_done && (owner_q == OWN_I);
        bus.d_valid = rst && slot_done && (owner_q == OWN_D);
        bus.i_rdata = bus.i_valid ? bus.m_rdata : '0;
        bus.d_rdata = bus.d_valid ? bus.m_rdata : '0;
        bus.stall   = rst && ((bus.i_req && !win_i) || (bus.d_req && !win_d));
    end

    // State registers; reset drops any access in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef ARB_RR_EN
            last_d_q <= 1'b1;
`else
            starve_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            addr_q   <= bus.m_addr;
            wdata_q  <= bus.m_wdata;
`ifdef ARB_RR_EN
            last_d_q <= last_d_d;
`else
            starve_q <= starve_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at MEM_LAT 1, 2, 3.
module tb_mem_port_arbiter;
    logic clk;
    logic rst1, rst2, rst3;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4))
        u_lat1 (.clk(clk), .rst(rst1), .bus(bus1));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4))
        u_lat2 (.clk(clk), .rst(rst2), .bus(bus2));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4))
        u_lat3 (.clk(clk), .rst(rst3), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one-cycle-latency memory for the MEM_LAT=1 instance
    logic [31:0] mem [0:255];
    logic [31:0] rd1;
    assign bus1.m_rdata = rd1;
    assign bus2.m_rdata = 32'hA5A5_0002;
    assign bus3.m_rdata = 32'hCAFE_0003;

    always @(posedge clk) begin
        if (!rst1) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            rd1 <= '0;
        end else begin
            rd1 <= mem[bus1.m_addr[9:2]];
            case (bus1.m_wr)
                2'b01: mem[bus1.m_addr[9:2]][7:0]  <= bus1.m_wdata[7:0];
                2'b10: mem[bus1.m_addr[9:2]][15:0] <= bus1.m_wdata[15:0];
                2'b11: mem[bus1.m_addr[9:2]]       <= bus1.m_wdata;
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus1();
        bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_wr = 2'b00;
        bus1.d_addr = '0; bus1.d_wdata = '0;
    endtask

    initial begin
        rst1 = 0; rst2 = 0; rst3 = 0;
        idle_bus1();
        bus2.i_req = 0; bus2.i_addr = '0; bus2.d_req = 0; bus2.d_wr = 2'b00;
        bus2.d_addr = '0; bus2.d_wdata = '0;
        bus3.i_req = 0; bus3.i_addr = '0; bus3.d_req = 0; bus3.d_wr = 2'b00;
        bus3.d_addr = '0; bus3.d_wdata = '0;

        // 1: reset held with both requests high
        bus1.i_req = 1; bus1.d_req = 1; bus1.d_wr = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_i_gnt", bus1.i_gnt, 0);
            check("rst_d_gnt", bus1.d_gnt, 0);
            check("rst_i_valid", bus1.i_valid, 0);
            check("rst_d_valid", bus1.d_valid, 0);
            check("rst_m_wr", bus1.m_wr, 0);
            check("rst_stall", bus1.stall, 0);
            next_cycle();
        end
        idle_bus1();
        rst1 = 1;

        // 2: single fetch at 0x10
        bus1.i_req = 1; bus1.i_addr = 32'h10;
        @(negedge clk);
        check("f_i_gnt", bus1.i_gnt, 1);
        check("f_d_gnt", bus1.d_gnt, 0);
        check("f_m_addr", bus1.m_addr, 32'h10);
        check("f_m_wr", bus1.m_wr, 0);
        check("f_m_wdata", bus1.m_wdata, 0);
        next_cycle();
        bus1.i_req = 0;
        @(negedge clk);
        check("f_i_valid", bus1.i_valid, 1);
        check("f_i_rdata", bus1.i_rdata, 32'h1000_0004);
        check("f_d_valid", bus1.d_valid, 0);
        next_cycle();

        // 3: word write 0x5 to 0x40, then read it back
        bus1.d_req = 1; bus1.d_wr = 2'b11; bus1.d_addr = 32'h40; bus1.d_wdata = 32'h5;
        @(negedge clk);
        check("w_d_gnt", bus1.d_gnt, 1);
        check("w_m_wr", bus1.m_wr, 2'b11);
        check("w_m_addr", bus1.m_addr, 32'h40);
        check("w_m_wdata", bus1.m_wdata, 32'h5);
        next_cycle();
        bus1.d_req = 0; bus1.d_wr = 2'b00; bus1.d_wdata = '0;
        @(negedge clk);
        check("w_d_valid", bus1.d_valid, 1);
        check("w_m_wr_idle", bus1.m_wr, 0);
        check("w_m_addr_hold", bus1.m_addr, 32'h40);
        check("w_m_wdata_hold", bus1.m_wdata, 32'h5);
        check("w_stall_idle", bus1.stall, 0);
        next_cycle();
        bus1.d_req = 1; bus1.d_wr = 2'b00; bus1.d_addr = 32'h40;
        @(negedge clk);
        check("r_d_gnt", bus1.d_gnt, 1);
        check("r_m_wr", bus1.m_wr, 0);
        next_cycle();
        bus1.d_req = 0;
        @(negedge clk);
        check("r_d_valid", bus1.d_valid, 1);
        check("r_d_rdata", bus1.d_rdata, 32'h5);
        check("r_i_valid", bus1.i_valid, 0);
        next_cycle();

        // 4: starvation guard, both requests held
        bus1.i_req = 1; bus1.i_addr = 32'h20;
        bus1.d_req = 1; bus1.d_wr = 2'b00; bus1.d_addr = 32'h80;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("sv_i_gnt%0d", k), bus1.i_gnt, (k == 4) ? 1 : 0);
            check($sformatf("sv_d_gnt%0d", k), bus1.d_gnt, (k == 4) ? 0 : 1);
            check($sformatf("sv_m_addr%0d", k), bus1.m_addr, (k == 4) ? 32'h20 : 32'h80);
            check($sformatf("sv_d_valid%0d", k), bus1.d_valid, (k >= 1 && k <= 4 || k == 6) ? 1 : 0);
            check($sformatf("sv_i_valid%0d", k), bus1.i_valid, (k == 5) ? 1 : 0);
            check($sformatf("sv_stall%0d", k), bus1.stall, 1);
            next_cycle();
        end
        idle_bus1();
        next_cycle();

        // 5: MEM_LAT=3 back-to-back grants
        rst3 = 1;
        next_cycle();
        bus3.i_req = 1; bus3.i_addr = 32'h100;
        bus3.d_req = 1; bus3.d_wr = 2'b00; bus3.d_addr = 32'h200;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("bb_d_gnt%0d", k), bus3.d_gnt, (k % 3 == 0 && k < 12) ? 1 : 0);
            check($sformatf("bb_i_gnt%0d", k), bus3.i_gnt, (k == 12) ? 1 : 0);
            check($sformatf("bb_d_valid%0d", k), bus3.d_valid, (k % 3 == 0 && k > 0) ? 1 : 0);
            check($sformatf("bb_d_rdata%0d", k), bus3.d_rdata,
                  (k % 3 == 0 && k > 0) ? 32'hCAFE_0003 : 32'h0);
            check($sformatf("bb_stall%0d", k), bus3.stall, 1);
            next_cycle();
        end
        bus3.i_req = 0; bus3.d_req = 0;
        next_cycle();

        // 6: reset the cycle after D_GNT with MEM_LAT=2
        rst2 = 1;
        next_cycle();
        bus2.d_req = 1; bus2.d_wr = 2'b00; bus2.d_addr = 32'h44;
        @(negedge clk);
        check("mr_d_gnt", bus2.d_gnt, 1);
        next_cycle();
        bus2.d_req = 0;
        rst2 = 0;
        @(negedge clk);
        check("mr_d_valid_rst", bus2.d_valid, 0);
        next_cycle();
        rst2 = 1;
        bus2.i_req = 1; bus2.i_addr = 32'h30;
        @(negedge clk);
        check("mr_d_valid_after", bus2.d_valid, 0);
        check("mr_i_gnt", bus2.i_gnt, 1);
        check("mr_m_addr", bus2.m_addr, 32'h30);
        next_cycle();
        bus2.i_req = 0;
        @(negedge clk);
        check("mr_i_valid_early", bus2.i_valid, 0);
        next_cycle();
        @(negedge clk);
        check("mr_i_valid", bus2.i_valid, 1);
        check("mr_i_rdata", bus2.i_rdata, 32'hA5A5_0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
